decoder2_4_seq: RTL

- Registered 2-to-4 one-hot decoder with enable. It is the companion block to the team's 4-to-2 encoder and takes the encoder's 2-bit code back to a 4-bit one-hot select.
- Single pulse mode: drives one output line for a fixed number of cycles.
- Scan mode: rotates the select across all four lines, for digit/row strobing.
- Sits between control logic and multiplexed select lines.

---
 rtl/decoder2_4_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/decoder2_4_seq.sv
// Registered 2-to-4 one-hot decoder with enable: single timed pulse of line A,
// or a rotating scan across all four lines, each value held for HOLD cycles.
module decoder2_4_seq #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] A,
  input  logic       E,
  input  logic       load,
  input  logic       scan,
  output logic [3:0] Y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD_ST = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    y_q, y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        y_d    = 4'b0000;
        busy_d = 1'b0;
        if (E && load) begin
          y_d     = 4'b0001 << A;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          state_d = HOLD_ST;
        end else if (E && scan) begin
          idx_d   = 2'd0;
          y_d     = 4'b0001;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end

      HOLD_ST: begin
        if (!E) begin
          y_d     = 4'b0000;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          y_d     = 4'b0000;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      SCAN: begin
        // Abort wins over slot completion, so a dropped enable never yields done.
        if (!E) begin
          y_d     = 4'b0000;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (scan) begin
          idx_d = idx_q + 2'd1;
          y_d   = 4'b0001 << (idx_q + 2'd1);
          cnt_d = RELOAD;
        end else begin
          y_d     = 4'b0000;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        y_d     = 4'b0000;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      y_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
